// File: rtl/apb2axi_rd_collector_if.sv
// R-channel, directory-lookup and FIFO-push bundle for apb2axi_rd_collector.
// slave  : the collector's view (consumes R beats, pushes FIFO entries).
// master : the surrounding fabric's view (drives R beats, owns the FIFOs).
interface apb2axi_rd_collector_if #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4,
  parameter int TAG_W      = 4,
  parameter int RDF_W      = TAG_W + AXI_DATA_W + 3,
  parameter int CPL_W      = TAG_W + 12
);

  // AXI R channel
  logic                  rvalid;
  logic                  rready;
  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  // Directory lookup
  logic [TAG_W-1:0]      lkp_tag;
  logic [7:0]            lkp_len;

  // Read data FIFO push
  logic                  rdf_valid;
  logic                  rdf_ready;
  logic [RDF_W-1:0]      rdf_entry;

  // Completion FIFO push
  logic                  cpl_valid;
  logic                  cpl_ready;
  logic [CPL_W-1:0]      cpl_entry;

  modport slave (
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    output lkp_tag,
    input  lkp_len,
    output rdf_valid, rdf_entry,
    input  rdf_ready,
    output cpl_valid, cpl_entry,
    input  cpl_ready
  );

  modport master (
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    input  lkp_tag,
    output lkp_len,
    input  rdf_valid, rdf_entry,
    output rdf_ready,
    input  cpl_valid, cpl_entry,
    output cpl_ready
  );

endinterface

// File: rtl/apb2axi_rd_collector.sv
// apb2axi_rd_collector: read-response collection stage of the APB2AXI converter.
// Tags each accepted R beat into a read-data FIFO entry and, on rlast, emits
// one completion entry with the merged (worst) response, error flag and beat
// count tracked per tag.
// Optional feature macro: APB2AXI_RD_LEN_CHECK_EN -- when defined, the error
// flag of a completion also reports a beat count that disagrees with the
// directory's AXI len for that tag (early or late rlast).
module apb2axi_rd_collector #(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4,
  parameter int TAG_W      = 4,
  parameter int RDF_W      = TAG_W + AXI_DATA_W + 3,
  parameter int CPL_W      = TAG_W + 12
) (
  input  logic                   clk,
  input  logic                   rst,
  apb2axi_rd_collector_if.slave  bus
);

  localparam int NTAG = 1 << TAG_W;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
    logic [1:0]            resp;
  } rdf_entry_t;

  typedef struct packed {
    logic                  is_write;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            resp;
    logic                  error;
    logic [7:0]            num_beats;
  } completion_entry_t;

  // Per-tag burst state
  logic [7:0]        beat_cnt_q   [NTAG];
  logic [1:0]        worst_resp_q [NTAG];

  // Output stages
  logic              rdf_valid_q;
  rdf_entry_t        rdf_entry_q;
  logic              cpl_valid_q;
  completion_entry_t cpl_entry_q;

  // Combinational datapath
  logic [TAG_W-1:0]  tag;
  logic [7:0]        cur_cnt;
  logic [1:0]        cur_worst;
  logic [1:0]        merged;
  logic [7:0]        cnt_sat;
  logic              len_err;
  logic              rdf_free;
  logic              cpl_free;
  logic              rready;
  logic              accept;
  logic              accept_last;
  rdf_entry_t        rdf_d;
  completion_entry_t cpl_d;

`ifndef APB2AXI_RD_LEN_CHECK_EN
  // Directory length is only consumed by the length check.
  logic unused_lkp_len;
  assign unused_lkp_len = ^bus.lkp_len;
`endif

  // Lookup, response merge, readiness and next-entry formation.
  always_comb begin
    tag       = bus.rid[TAG_W-1:0];
    cur_cnt   = beat_cnt_q[tag];
    cur_worst = worst_resp_q[tag];
    // DECERR > SLVERR > EXOKAY > OKAY matches plain unsigned ordering.
    merged    = (bus.rresp > cur_worst) ? bus.rresp : cur_worst;
    cnt_sat   = (cur_cnt == 8'hFF) ? 8'hFF : cur_cnt + 8'd1;

    len_err   = 1'b0;
`ifdef APB2AXI_RD_LEN_CHECK_EN
    // beat_cnt+1 != lkp_len+1 reduces to beat_cnt != lkp_len; comparing the
    // unincremented values keeps a full 256-beat burst (len 255) error-free.
    len_err   = (cur_cnt != bus.lkp_len);
`endif

    rdf_free    = !rdf_valid_q || bus.rdf_ready;
    cpl_free    = !cpl_valid_q || bus.cpl_ready;
    // Held low while reset is asserted; follows the equation right after.
    rready      = !rst && rdf_free && (!bus.rlast || cpl_free);
    accept      = bus.rvalid && rready;
    accept_last = accept && bus.rlast;

    rdf_d.tag  = tag;
    rdf_d.data = bus.rdata;
    rdf_d.last = bus.rlast;
    rdf_d.resp = bus.rresp;

    cpl_d.is_write  = 1'b0;
    cpl_d.tag       = tag;
    cpl_d.resp      = merged;
    cpl_d.error     = merged[1] || len_err;
    cpl_d.num_beats = cnt_sat;
  end

  // Per-tag beat counter and worst response; cleared when a burst completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NTAG; i++) begin
        beat_cnt_q[i]   <= '0;
        worst_resp_q[i] <= '0;
      end
    end else if (accept) begin
      if (bus.rlast) begin
        beat_cnt_q[tag]   <= '0;
        worst_resp_q[tag] <= '0;
      end else begin
        beat_cnt_q[tag]   <= cnt_sat;
        worst_resp_q[tag] <= merged;
      end
    end
  end

  // Read-data stage: reload on accept (even while draining), else drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdf_valid_q <= 1'b0;
      rdf_entry_q <= '0;
    end else if (accept) begin
      rdf_valid_q <= 1'b1;
      rdf_entry_q <= rdf_d;
    end else if (bus.rdf_ready) begin
      rdf_valid_q <= 1'b0;
    end
  end

  // Completion stage: reload on an accepted last beat, else drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpl_valid_q <= 1'b0;
      cpl_entry_q <= '0;
    end else if (accept_last) begin
      cpl_valid_q <= 1'b1;
      cpl_entry_q <= cpl_d;
    end else if (bus.cpl_ready) begin
      cpl_valid_q <= 1'b0;
    end
  end

  assign bus.rready    = rready;
  assign bus.lkp_tag   = tag;
  assign bus.rdf_valid = rdf_valid_q;
  assign bus.rdf_entry = rdf_entry_q;
  assign bus.cpl_valid = cpl_valid_q;
  assign bus.cpl_entry = cpl_entry_q;

endmodule

// File: tb/tb_apb2axi_rd_collector.sv
// Directed self-checking bench for apb2axi_rd_collector (default parameters).
module tb_apb2axi_rd_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb2axi_rd_collector_if bus ();

  apb2axi_rd_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [70:0] rdf_exp(input logic [3:0] tag, input logic [63:0] d,
                                          input logic last, input logic [1:0] resp);
    return {tag, d, last, resp};
  endfunction

  function automatic logic [15:0] cpl_exp(input logic [3:0] tag, input logic [1:0] resp,
                                          input logic err, input logic [7:0] nb);
    return {1'b0, tag, resp, err, nb};
  endfunction

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [3:0] id, input logic [63:0] d, input logic [1:0] rs,
                      input logic l, input logic [7:0] len);
    int waited = 0;
    bus.rvalid  = 1'b1;
    bus.rid     = id;
    bus.rdata   = d;
    bus.rresp   = rs;
    bus.rlast   = l;
    bus.lkp_len = len;
    @(negedge clk);
    while (!bus.rready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.rready) begin
      n_cmp++;
      n_fail++;
      $error("FAIL send_timeout: observed rready=0 expected rready=1 (tag %0h)", id);
    end
    @(posedge clk);
    #1;
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic e_t1, e_t2;

  initial begin
    bus.rvalid    = 1'b1;
    bus.rid       = '0;
    bus.rdata     = '0;
    bus.rresp     = '0;
    bus.rlast     = 1'b0;
    bus.lkp_len   = '0;
    bus.rdf_ready = 1'b1;
    bus.cpl_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_rready",    bus.rready,    0);
    chk("rst_rdf_valid", bus.rdf_valid, 0);
    chk("rst_cpl_valid", bus.cpl_valid, 0);
    chk("rst_rdf_entry", bus.rdf_entry, 0);
    chk("rst_cpl_entry", bus.cpl_entry, 0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.rvalid = 1'b0;
    #1;
    chk("post_rst_rready", bus.rready, 1);

    // Single burst: tag 3, len 3, four OKAY beats back to back
    for (int i = 0; i < 4; i++) begin
      send(4'd3, 64'h10 + 64'(i), 2'b00, i == 3, 8'd3);
      chk("burst_rdf_valid", bus.rdf_valid, 1);
      chk("burst_rdf_entry", bus.rdf_entry, rdf_exp(4'd3, 64'h10 + 64'(i), i == 3, 2'b00));
      chk("burst_cpl_valid", bus.cpl_valid, (i == 3) ? 1 : 0);
    end
    chk("burst_cpl_entry", bus.cpl_entry, cpl_exp(4'd3, 2'd0, 1'b0, 8'd4));
    idle();
    chk("burst_rdf_drained", bus.rdf_valid, 0);
    chk("burst_cpl_drained", bus.cpl_valid, 0);

    // Merged response: OKAY then SLVERR
    send(4'd5, 64'h50, 2'b00, 1'b0, 8'd1);
    send(4'd5, 64'h51, 2'b10, 1'b1, 8'd1);
    chk("merge_cpl_valid", bus.cpl_valid, 1);
    chk("merge_cpl_entry", bus.cpl_entry, cpl_exp(4'd5, 2'd2, 1'b1, 8'd2));
    idle();

    // Interleaving: 1,2,1,2(last),1(last), both tags report len 2
`ifdef APB2AXI_RD_LEN_CHECK_EN
    e_t2 = 1'b1;  // 2 beats vs len 2 -> expected 3
    e_t1 = 1'b0;  // 3 beats vs len 2 -> matches
`else
    e_t2 = 1'b0;
    e_t1 = 1'b0;
`endif
    send(4'd1, 64'h100, 2'b00, 1'b0, 8'd2);
    send(4'd2, 64'h200, 2'b00, 1'b0, 8'd2);
    send(4'd1, 64'h101, 2'b00, 1'b0, 8'd2);
    send(4'd2, 64'h201, 2'b00, 1'b1, 8'd2);
    chk("ilv_cpl_t2", bus.cpl_entry, cpl_exp(4'd2, 2'd0, e_t2, 8'd2));
    send(4'd1, 64'h102, 2'b00, 1'b1, 8'd2);
    chk("ilv_cpl_t1_valid", bus.cpl_valid, 1);
    chk("ilv_cpl_t1", bus.cpl_entry, cpl_exp(4'd1, 2'd0, e_t1, 8'd3));
    chk("ilv_rdf_last", bus.rdf_entry, rdf_exp(4'd1, 64'h102, 1'b1, 2'b00));
    idle();

    // Backpressure on the read-data FIFO
    bus.rdf_ready = 1'b0;
    send(4'd4, 64'hA0, 2'b00, 1'b0, 8'd2);
    chk("bp_rdf_valid", bus.rdf_valid, 1);
    bus.rvalid  = 1'b1;
    bus.rid     = 4'd4;
    bus.rdata   = 64'hA1;
    bus.rresp   = 2'b01;
    bus.rlast   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rready", bus.rready, 0);
      chk("bp_rdf_stable", bus.rdf_entry, rdf_exp(4'd4, 64'hA0, 1'b0, 2'b00));
    end
    @(posedge clk);
    #1;
    bus.rdf_ready = 1'b1;
    send(4'd4, 64'hA1, 2'b01, 1'b0, 8'd2);
    chk("bp_rdf_b", bus.rdf_entry, rdf_exp(4'd4, 64'hA1, 1'b0, 2'b01));
    send(4'd4, 64'hA2, 2'b00, 1'b1, 8'd2);
    chk("bp_cpl", bus.cpl_entry, cpl_exp(4'd4, 2'd1, 1'b0, 8'd3));
    idle();

    // Completion stall
    bus.cpl_ready = 1'b0;
    send(4'd6, 64'h60, 2'b00, 1'b1, 8'd0);
    chk("stall_cpl_valid", bus.cpl_valid, 1);
    // a non-last beat still flows while cpl is occupied
    send(4'd10, 64'hB0, 2'b00, 1'b0, 8'd3);
    chk("stall_nonlast_rdf", bus.rdf_entry, rdf_exp(4'd10, 64'hB0, 1'b0, 2'b00));
    bus.rvalid  = 1'b1;
    bus.rid     = 4'd9;
    bus.rdata   = 64'h90;
    bus.rresp   = 2'b11;
    bus.rlast   = 1'b1;
    bus.lkp_len = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rready", bus.rready, 0);
      chk("stall_cpl_hold", bus.cpl_entry, cpl_exp(4'd6, 2'd0, 1'b0, 8'd1));
    end
    @(posedge clk);
    #1;
    bus.cpl_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_rready", bus.rready, 1);
    @(posedge clk);
    #1;
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    chk("stall_cpl_new_valid", bus.cpl_valid, 1);
    chk("stall_cpl_new", bus.cpl_entry, cpl_exp(4'd9, 2'd3, 1'b1, 8'd1));
    idle();

    // Reset mid-burst: tag 7, 2 of 4 beats, then replay all 4
    send(4'd7, 64'h70, 2'b10, 1'b0, 8'd3);
    send(4'd7, 64'h71, 2'b00, 1'b0, 8'd3);
    rst        = 1'b1;
    bus.rvalid = 1'b1;
    #1;
    chk("mid_rst_rready",    bus.rready,    0);
    chk("mid_rst_rdf_valid", bus.rdf_valid, 0);
    chk("mid_rst_cpl_valid", bus.cpl_valid, 0);
    chk("mid_rst_rdf_entry", bus.rdf_entry, 0);
    chk("mid_rst_cpl_entry", bus.cpl_entry, 0);
    bus.rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(4'd7, 64'h70 + 64'(i), 2'b00, i == 3, 8'd3);
    end
    chk("replay_cpl", bus.cpl_entry, cpl_exp(4'd7, 2'd0, 1'b0, 8'd4));
    idle();

    // Beat count saturation: 300 beats on tag 0, one EXOKAY in the middle
    for (int i = 0; i < 300; i++) begin
      send(4'd0, 64'(i), (i == 150) ? 2'b01 : 2'b00, i == 299, 8'd255);
    end
    chk("sat_cpl", bus.cpl_entry, cpl_exp(4'd0, 2'd1, 1'b0, 8'd255));
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
